rename_register_file: RTL

RENAME_REGISTER_FILE -- requirements
Module: rename_register_file

---
 rtl/rename_register_file_pkg.sv | 15 +
 rtl/rename_register_file_if.sv | 39 +++
 rtl/rename_register_file.sv | 85 ++++++++
 3 files changed

// File: rtl/rename_register_file_pkg.sv
// Shared header for the ROB / decoder / rename register file.
// Holds the common word, register-index and ROB-tag widths, plus the NULL_TAG and ZERO_WORD constants.
package rename_register_file_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int REG_INDEX_WIDTH = 5;
    localparam int ROB_TAG_WIDTH   = 4;

    localparam logic [ROB_TAG_WIDTH-1:0] NULL_TAG  = '0;
    localparam logic [WORD_WIDTH-1:0]    ZERO_WORD = '0;

    typedef logic [WORD_WIDTH-1:0]      word_t;
    typedef logic [REG_INDEX_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/rename_register_file_if.sv
// Decoder, ROB-commit and rollback signals seen by the rename register file.
// The master modport belongs to the ROB/decoder side; the slave modport belongs to the register file.
interface rename_register_file_if
    import rename_register_file_pkg::*;
#(
    parameter int ROB_TAG_W = ROB_TAG_WIDTH
);
    logic                 rollback_in;

    logic                 dec_issue_in;
    reg_idx_t             dec_rd_in;
    logic [ROB_TAG_W-1:0] dec_tag_in;
    reg_idx_t             dec_rs1_in;
    reg_idx_t             dec_rs2_in;
    word_t                dec_Vj_out;
    word_t                dec_Vk_out;
    logic [ROB_TAG_W-1:0] dec_Qj_out;
    logic [ROB_TAG_W-1:0] dec_Qk_out;

    logic                 commit_rf_signal_in;
    logic [ROB_TAG_W-1:0] commit_tag_in;
    word_t                commit_data_in;
    reg_idx_t             commit_target_in;

    modport master (
        output rollback_in,
        output dec_issue_in, dec_rd_in, dec_tag_in, dec_rs1_in, dec_rs2_in,
        input  dec_Vj_out, dec_Vk_out, dec_Qj_out, dec_Qk_out,
        output commit_rf_signal_in, commit_tag_in, commit_data_in, commit_target_in
    );

    modport slave (
        input  rollback_in,
        input  dec_issue_in, dec_rd_in, dec_tag_in, dec_rs1_in, dec_rs2_in,
        output dec_Vj_out, dec_Vk_out, dec_Qj_out, dec_Qk_out,
        input  commit_rf_signal_in, commit_tag_in, commit_data_in, commit_target_in
    );

endinterface

// File: rtl/rename_register_file.sv
// Architectural register file with per-register producer tags for Tomasulo-style renaming.
// Reads are combinational, with a bypass for a commit in the same cycle. Writes take effect on the next rising clk edge.
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter int ROB_TAG_W = ROB_TAG_WIDTH,
    parameter int REG_NUM   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rename_register_file_if.slave rf
);

    localparam int                   RD_W   = WORD_WIDTH + ROB_TAG_W;
    localparam logic [ROB_TAG_W-1:0] NULL_Q = ROB_TAG_W'(NULL_TAG);

    word_t                value [REG_NUM];
    logic [ROB_TAG_W-1:0] qi    [REG_NUM];

    // A commit bypasses into the read only if it is still the newest producer of that register.
    function automatic logic [RD_W-1:0] read_port(
        input reg_idx_t             rs,
        input word_t                cur_v,
        input logic [ROB_TAG_W-1:0] cur_q,
        input logic                 cm_vld,
        input reg_idx_t             cm_tgt,
        input logic [ROB_TAG_W-1:0] cm_tag,
        input word_t                cm_data
    );
        logic [RD_W-1:0] res;
        if (rs == '0)
            res = {ZERO_WORD, NULL_Q};
        else if (cm_vld && cm_tgt == rs && cm_tag == cur_q)
            res = {cm_data, NULL_Q};
        else
            res = {cur_v, cur_q};
        return res;
    endfunction

    reg_idx_t             rs_idx [2];
    word_t                rd_v   [2];
    logic [ROB_TAG_W-1:0] rd_q   [2];

    assign rs_idx[0] = rf.dec_rs1_in;
    assign rs_idx[1] = rf.dec_rs2_in;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign {rd_v[p], rd_q[p]} = read_port(rs_idx[p], value[rs_idx[p]], qi[rs_idx[p]],
                                              rf.commit_rf_signal_in, rf.commit_target_in,
                                              rf.commit_tag_in, rf.commit_data_in);
    end

    assign rf.dec_Vj_out = rd_v[0];
    assign rf.dec_Qj_out = rd_q[0];
    assign rf.dec_Vk_out = rd_v[1];
    assign rf.dec_Qk_out = rd_q[1];

    logic issue_ok;
    assign issue_ok = rf.dec_issue_in && !rf.rollback_in;

    // Entry 0 is written only by reset, so x0 stays zero with no producer tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_NUM; r++) begin
                value[r] <= ZERO_WORD;
                qi[r]    <= NULL_Q;
            end
        end else begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (rf.commit_rf_signal_in && rf.commit_target_in == REG_INDEX_WIDTH'(r))
                    value[r] <= rf.commit_data_in;

                // Priority order: rollback, then a new rename, then clearing the tag of a matching commit.
                if (rf.rollback_in)
                    qi[r] <= NULL_Q;
                else if (issue_ok && rf.dec_rd_in == REG_INDEX_WIDTH'(r))
                    qi[r] <= rf.dec_tag_in;
                else if (rf.commit_rf_signal_in && rf.commit_target_in == REG_INDEX_WIDTH'(r)
                         && qi[r] == rf.commit_tag_in)
                    qi[r] <= NULL_Q;
            end
        end
    end

endmodule
